demux4_seq: RTL and testbench
=============================

DEMUX4_SEQ -- requirements
Module: demux4_seq

Interface
REQ-001 Parameter WIDTH, default 1, data width of input word and of each output channel.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port din  input  WIDTH  input data word.
REQ-005 Port in_valid  input  1  producer offers din this cycle.
REQ-006 Port in_ready  output  1  block accepts din this cycle; transfer when in_valid && in_ready.
REQ-007 Port j  input  1  channel select MSB (manual mode).
REQ-008 Port k  input  1  channel select LSB (manual mode).
REQ-009 Port auto_mode  input  1  1 = round-robin channel selection, 0 = select from {j,k}.
REQ-010 Port o0, o1, o2, o3  output  WIDTH each  registered channel data.
REQ-011 Port o_full  output  4  bit i = channel i holds an unconsumed word.
REQ-012 Port o_ack  input  4  bit i = consumer of channel i takes its word this cycle.
REQ-013 Port rr_ptr  output  2  current round-robin channel index.

Function
REQ-014 Target channel tgt SHALL be rr_ptr when auto_mode=1, else {j,k} (j MSB: 00->o0, 01->o1, 10->o2, 11->o3).
REQ-015 in_ready SHALL be combinational: !o_full[tgt] || o_ack[tgt].
REQ-016 On transfer, din SHALL be written to o<tgt> and o_full[tgt] set on the same clock edge (1-cycle latency); other channels unchanged.
REQ-017 o_ack[i] with o_full[i]=1 SHALL clear o_full[i] at the edge unless a transfer targets i the same cycle, in which case o_full[i] stays 1 and o<i> takes the new word.
REQ-018 o_ack[i] with o_full[i]=0 SHALL be ignored.
REQ-019 o<i> SHALL hold its value while o_full[i]=1 and no new write; data SHALL also hold (not clear) after ack.
REQ-020 rr_ptr SHALL increment modulo 4 (3->0 wrap) only on a transfer while auto_mode=1; no transfer = no advance.
REQ-021 In manual mode rr_ptr SHALL hold; switching modes SHALL not reset it.
REQ-022 When tgt channel is full and not acked, in_ready=0 and no state changes for the input; the block SHALL NOT redirect the word to another channel.
REQ-023 Changes on j, k, auto_mode without in_valid SHALL have no effect on state.

Reset
REQ-024 While rst=1: o0..o3 = 0, o_full = 4'b0000, rr_ptr = 0, asynchronously, regardless of clk.
REQ-025 Reset asserted mid-operation SHALL discard all held words; in_ready evaluates to 1 during and after reset (all channels empty).
REQ-026 First transfer SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-027 Shared package SHALL hold channel count (4), select width (2) and default WIDTH constant.
REQ-028 One sub-module demux_chan (single-entry holding register with full flag, write/ack inputs) SHALL be instantiated four times; top holds select logic and rr_ptr.

Verification
REQ-029 Manual: WIDTH=1, j=1,k=0, din=1, in_valid 1 cycle -> next cycle o2=1, o_full=0100, others 0.
REQ-030 Backpressure: o_full[3]=1, no ack, j=1,k=1, in_valid=1 -> in_ready=0, o3 unchanged for 5 cycles; assert o_ack[3] -> transfer same cycle, o_full[3] stays 1, o3 = new din.
REQ-031 Auto: auto_mode=1, 5 consecutive transfers din=1,0,1,1,0 with all o_ack=1 -> writes to o0,o1,o2,o3,o0; rr_ptr sequence 0,1,2,3,0,1.
REQ-032 Auto stall: auto_mode=1, rr_ptr=2, o_full[2]=1 no ack -> in_ready=0, rr_ptr stays 2 though channels 0,1,3 empty.
REQ-033 Reset mid-run: o_full=1111, rr_ptr=3, pulse rst between clock edges -> immediately o_full=0000, rr_ptr=0, o0..o3=0, in_ready=1.
REQ-034 Exhaustive manual select: all four {j,k} values with din alternating 1/0 -> each word appears only on its selected output.

Source files
------------

// File: rtl/demux4_seq_pkg.sv
// Shared constants for the four-channel sequential demultiplexer.
package demux4_seq_pkg;

    localparam int NUM_CH        = 4;
    localparam int SEL_W         = 2;
    localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/demux_chan.sv
// Single-entry channel holding register: a write loads data and sets full,
// an ack empties the slot but leaves the data word in place.
module demux_chan #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             ack,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    logic [WIDTH-1:0] data_p0;
    logic             full_p0;

    // Holding stage: a same-cycle write wins over an ack so the slot stays full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p0 <= '0;
            full_p0 <= 1'b0;
        end else begin
            if (wr) begin
                data_p0 <= din;
                full_p0 <= 1'b1;
            end else if (ack) begin
                full_p0 <= 1'b0;
            end
        end
    end

    assign dout = data_p0;
    assign full = full_p0;

endmodule

// File: rtl/demux4_seq.sv
// Four-channel demultiplexer with valid/ready input, manual {j,k} or
// round-robin channel selection, and one holding register per channel.
module demux4_seq
    import demux4_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  din,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              j,
    input  logic              k,
    input  logic              auto_mode,
    output logic [WIDTH-1:0]  o0,
    output logic [WIDTH-1:0]  o1,
    output logic [WIDTH-1:0]  o2,
    output logic [WIDTH-1:0]  o3,
    output logic [NUM_CH-1:0] o_full,
    input  logic [NUM_CH-1:0] o_ack,
    output logic [SEL_W-1:0]  rr_ptr
);

    logic [SEL_W-1:0]  tgt;
    logic              xfer;
    logic [NUM_CH-1:0] wr;
    logic [WIDTH-1:0]  ch_data [NUM_CH];

    // A word only ever goes to its selected channel; a full, unacked target stalls.
    always_comb begin
        tgt      = auto_mode ? rr_ptr : {j, k};
        in_ready = !o_full[tgt] || o_ack[tgt];
        xfer     = in_valid && in_ready;
        wr       = '0;
        if (xfer) begin
            wr[tgt] = 1'b1;
        end
    end

    // Round-robin pointer stage: advances only on an auto-mode transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (xfer && auto_mode) begin
            rr_ptr <= rr_ptr + SEL_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        demux_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .wr   (wr[i]),
            .ack  (o_ack[i]),
            .din  (din),
            .dout (ch_data[i]),
            .full (o_full[i])
        );
    end

    assign o0 = ch_data[0];
    assign o1 = ch_data[1];
    assign o2 = ch_data[2];
    assign o3 = ch_data[3];

endmodule

// File: tb/tb_demux4_seq.sv
// Scoreboard bench for demux4_seq: expected writes are queued when driven
// and popped after the clock edge that should have performed them.
module tb_demux4_seq;

    localparam int W = 1;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         in_valid;
    logic         in_ready;
    logic         j;
    logic         k;
    logic         auto_mode;
    logic [W-1:0] o0, o1, o2, o3;
    logic [3:0]   o_full;
    logic [3:0]   o_ack;
    logic [1:0]   rr_ptr;

    typedef struct {
        logic [1:0]   ch;
        logic [W-1:0] data;
    } sb_t;

    sb_t          sb_q [$];
    logic [3:0]   full_m;
    logic [W-1:0] data_m [4];
    logic [1:0]   rr_m;
    int           n_cmp;
    int           n_err;

    demux4_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .j         (j),
        .k         (k),
        .auto_mode (auto_mode),
        .o0        (o0),
        .o1        (o1),
        .o2        (o2),
        .o3        (o3),
        .o_full    (o_full),
        .o_ack     (o_ack),
        .rr_ptr    (rr_ptr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] get_o(input logic [1:0] c);
        case (c)
            2'd0:    return o0;
            2'd1:    return o1;
            2'd2:    return o2;
            default: return o3;
        endcase
    endfunction

    function automatic logic [4*W-1:0] model_data();
        return {data_m[3], data_m[2], data_m[1], data_m[0]};
    endfunction

    task automatic model_reset();
        full_m = '0;
        rr_m   = '0;
        for (int i = 0; i < 4; i++) data_m[i] = '0;
        sb_q.delete();
    endtask

    // Queue the expected write, advance one rising edge, then update the model.
    task automatic tick();
        logic [1:0] t;
        logic       rdy;
        logic       xf;
        t   = auto_mode ? rr_m : {j, k};
        rdy = !full_m[t] || o_ack[t];
        xf  = in_valid && rdy;
        if (xf) sb_q.push_back('{ch: t, data: din});
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (o_ack[i]) full_m[i] = 1'b0;
        if (xf) begin
            full_m[t] = 1'b1;
            data_m[t] = din;
            if (auto_mode) rr_m = rr_m + 2'd1;
        end
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        o_ack    = '0;
        rst      = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        sb_t e;
        rst = 1'b1; din = '0; in_valid = 1'b0; j = 1'b0; k = 1'b0;
        auto_mode = 1'b0; o_ack = '0;
        model_reset();
        #2;
        n_cmp++; if (o_full !== 4'b0000) begin n_err++; $display("FAIL reset_full got=%b exp=%b", o_full, 4'b0000); end
        n_cmp++; if (rr_ptr !== 2'd0) begin n_err++; $display("FAIL reset_rr got=%0d exp=0", rr_ptr); end
        n_cmp++; if ({o3, o2, o1, o0} !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", {o3, o2, o1, o0}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_manual();
        sb_t e;
        j = 1'b1; k = 1'b0; din = 1'b1; in_valid = 1'b1; o_ack = '0; auto_mode = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL manual_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++; if (get_o(e.ch) !== e.data) begin n_err++; $display("FAIL manual_word ch=%0d got=%h exp=%h", e.ch, get_o(e.ch), e.data); end
        end
        n_cmp++; if (o2 !== 1'b1) begin n_err++; $display("FAIL manual_o2 got=%b exp=1", o2); end
        n_cmp++; if (o_full !== 4'b0100) begin n_err++; $display("FAIL manual_full got=%b exp=0100", o_full); end
        n_cmp++; if ({o3, o1, o0} !== 3'b000) begin n_err++; $display("FAIL manual_others got=%b exp=000", {o3, o1, o0}); end
    endtask

    task automatic test_exhaustive_select();
        sb_t e;
        logic [1:0] s;
        do_reset();
        din = 1'b0;
        for (int i = 0; i < 4; i++) begin
            // Wiggle selects and mode with no valid: state must not move.
            in_valid = 1'b0; j = ~j; k = ~k; auto_mode = 1'b1;
            tick();
            n_cmp++; if (o_full !== full_m || rr_ptr !== rr_m) begin n_err++; $display("FAIL idle_sel full=%b/%b rr=%0d/%0d", o_full, full_m, rr_ptr, rr_m); end
            s = 2'(i);
            auto_mode = 1'b0; j = s[1]; k = s[0]; din = ~din; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++; if (e.ch !== s || get_o(e.ch) !== e.data) begin n_err++; $display("FAIL sel_word ch=%0d got=%h exp=%h", s, get_o(s), e.data); end
            end else begin
                n_cmp++; n_err++; $display("FAIL sel_nowrite ch=%0d", s);
            end
            n_cmp++; if ({o3, o2, o1, o0} !== model_data()) begin n_err++; $display("FAIL sel_data got=%h exp=%h", {o3, o2, o1, o0}, model_data()); end
            n_cmp++; if (o_full !== full_m) begin n_err++; $display("FAIL sel_full got=%b exp=%b", o_full, full_m); end
        end
        n_cmp++; if ({o3, o2, o1, o0} !== 4'b0101) begin n_err++; $display("FAIL sel_final got=%b exp=0101", {o3, o2, o1, o0}); end
    endtask

    task automatic test_backpressure();
        sb_t e;
        do_reset();
        auto_mode = 1'b0; j = 1'b1; k = 1'b1; din = 1'b1; in_valid = 1'b1;
        tick();
        if (sb_q.size() > 0) e = sb_q.pop_front();
        din = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", c, in_ready); end
            tick();
            n_cmp++; if (o3 !== 1'b1 || o_full !== 4'b1000 || sb_q.size() != 0) begin n_err++; $display("FAIL bp_hold cyc=%0d o3=%b full=%b exp o3=1 full=1000", c, o3, o_full); end
        end
        o_ack = 4'b1000;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ack_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0; o_ack = '0;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++; if (get_o(e.ch) !== e.data) begin n_err++; $display("FAIL bp_word got=%h exp=%h", get_o(e.ch), e.data); end
        end
        n_cmp++; if (o3 !== 1'b0 || o_full !== 4'b1000) begin n_err++; $display("FAIL bp_after o3=%b full=%b exp o3=0 full=1000", o3, o_full); end
        // Ack with no write empties the slot but keeps the data word.
        o_ack = 4'b1001;
        tick();
        o_ack = '0;
        n_cmp++; if (o_full !== 4'b0000 || o3 !== 1'b0 || {o3, o2, o1, o0} !== model_data()) begin n_err++; $display("FAIL ack_clear full=%b data=%h exp full=0000 data=%h", o_full, {o3, o2, o1, o0}, model_data()); end
    endtask

    task automatic test_auto();
        sb_t e;
        logic [W-1:0] vals [5];
        logic [1:0]   exp_ch [6];
        vals   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        auto_mode = 1'b1; o_ack = 4'hF; in_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            din = vals[n];
            #1;
            n_cmp++; if (rr_ptr !== exp_ch[n] || in_ready !== 1'b1) begin n_err++; $display("FAIL auto_pre n=%0d rr=%0d rdy=%b exp rr=%0d rdy=1", n, rr_ptr, in_ready, exp_ch[n]); end
            tick();
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++; if (e.ch !== exp_ch[n] || get_o(exp_ch[n]) !== vals[n]) begin n_err++; $display("FAIL auto_word n=%0d ch=%0d got=%h exp=%h", n, exp_ch[n], get_o(exp_ch[n]), vals[n]); end
            end else begin
                n_cmp++; n_err++; $display("FAIL auto_nowrite n=%0d", n);
            end
            n_cmp++; if (o_full !== full_m) begin n_err++; $display("FAIL auto_full n=%0d got=%b exp=%b", n, o_full, full_m); end
        end
        in_valid = 1'b0; o_ack = '0;
        n_cmp++; if (rr_ptr !== exp_ch[5]) begin n_err++; $display("FAIL auto_rr_end got=%0d exp=%0d", rr_ptr, exp_ch[5]); end
        auto_mode = 1'b0; j = 1'b0; k = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        n_cmp++; if (rr_ptr !== 2'd1) begin n_err++; $display("FAIL manual_rr_hold got=%0d exp=1", rr_ptr); end
    endtask

    task automatic test_auto_stall();
        sb_t e;
        do_reset();
        auto_mode = 1'b0; j = 1'b1; k = 1'b0; din = 1'b1; in_valid = 1'b1;
        tick();
        auto_mode = 1'b1;
        tick();
        tick();
        in_valid = 1'b0; o_ack = 4'b0011;
        tick();
        o_ack = '0;
        while (sb_q.size() > 0) e = sb_q.pop_front();
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", c, in_ready); end
            tick();
            n_cmp++; if (rr_ptr !== 2'd2 || o_full !== 4'b0100) begin n_err++; $display("FAIL stall_state cyc=%0d rr=%0d full=%b exp rr=2 full=0100", c, rr_ptr, o_full); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midrun();
        sb_t e;
        do_reset();
        auto_mode = 1'b1; o_ack = '0; in_valid = 1'b1; din = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        auto_mode = 1'b0; j = 1'b1; k = 1'b1;
        tick();
        in_valid = 1'b1;
        n_cmp++; if (o_full !== 4'b1111 || rr_ptr !== 2'd3) begin n_err++; $display("FAIL pre_rst full=%b rr=%0d exp full=1111 rr=3", o_full, rr_ptr); end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (o_full !== 4'b0000 || rr_ptr !== 2'd0) begin n_err++; $display("FAIL async_rst full=%b rr=%0d exp full=0000 rr=0", o_full, rr_ptr); end
        n_cmp++; if ({o3, o2, o1, o0} !== 4'b0000 || in_ready !== 1'b1) begin n_err++; $display("FAIL async_rst_data data=%b rdy=%b exp data=0000 rdy=1", {o3, o2, o1, o0}, in_ready); end
        rst = 1'b0;
        model_reset();
        din = 1'b1;
        tick();
        in_valid = 1'b0;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++; if (get_o(e.ch) !== e.data || o_full !== 4'b1000) begin n_err++; $display("FAIL post_rst o3=%b full=%b exp o3=1 full=1000", o3, o_full); end
        end else begin
            n_cmp++; n_err++; $display("FAIL post_rst_nowrite");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_manual();
        test_exhaustive_select();
        test_backpressure();
        test_auto();
        test_auto_stall();
        test_reset_midrun();
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
